// File: rtl/rtc_bus_pkg.sv
// RTC bus responder shared definitions.
// Register map, BCD limits and FSM encoding.
package rtc_bus_pkg;

  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_SEC  = 8'h21;
  localparam logic [7:0] REG_MIN  = 8'h22;
  localparam logic [7:0] REG_HOUR = 8'h23;

  localparam int HOLD_BIT = 0;

  localparam logic [7:0] SEC_LIM  = 8'h59;
  localparam logic [7:0] MIN_LIM  = 8'h59;
  localparam logic [7:0] HOUR_LIM = 8'h23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_PH = 2'd1,
    DATA_WR = 2'd2,
    DATA_RD = 2'd3
  } state_t;

endpackage

// File: rtl/rtc_bus_responder_bcd_inc.sv
// Two-digit BCD increment against an inclusive limit.
// Invalid digits or values past the limit wrap to 0x00 with carry.
module rtc_bus_responder_bcd_inc (
  input  logic [7:0] val,
  input  logic [7:0] limit,
  output logic [7:0] nxt,
  output logic       carry
);

  logic bad;
  logic wrap;

  // wrap on limit or on any malformed value, else step one digit
  always_comb begin
    bad   = (val[7:4] > 4'd9) ||
            (val[3:0] > 4'd9) ||
            (val > limit);
    wrap  = bad || (val == limit);
    carry = wrap;
    nxt   = 8'h00;
    if (!wrap) begin
      if (val[3:0] == 4'd9) begin
        nxt = {val[7:4] + 4'd1, 4'd0};
      end else begin
        nxt = {val[7:4], val[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC-chip side of the multiplexed AD bus.
// Register file, read-back drive and BCD clock.
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int LAR       = 8,
  parameter int REG_COUNT = 64,
  parameter int TICK_DIV  = 100000000
) (
  input  logic           clk,
  input  logic           rst,
  inout  wire  [LAR-1:0] AD0_AD7,
  input  logic           AD,
  input  logic           CS,
  input  logic           WR,
  input  logic           RD,
  output logic [LAR-1:0] addr_latched,
  output logic           wr_pulse,
  output logic           rd_active
);

  localparam int AW = $clog2(REG_COUNT);
  localparam int LW = LAR + 1;
  localparam int CW = $clog2(TICK_DIV);

  localparam logic [LW-1:0] REG_LIM = LW'(REG_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  localparam logic [AW-1:0] A_CTRL = REG_CTRL[AW-1:0];
  localparam logic [AW-1:0] A_SEC  = REG_SEC[AW-1:0];
  localparam logic [AW-1:0] A_MIN  = REG_MIN[AW-1:0];
  localparam logic [AW-1:0] A_HOUR = REG_HOUR[AW-1:0];

  logic [1:0]     ad_sy, cs_sy, wr_sy, rd_sy;
  logic           wr_q, rd_q;
  logic [LAR-1:0] d1, d2;

  logic ad_s, cs_s, wr_s, rd_s;
  logic wr_fall, wr_rise;
  logic rd_fall, rd_rise;
  logic err;

  state_t state, nstate;

  logic           latch_addr;
  logic           commit;
  logic [LAR-1:0] rd_data;

  logic [LAR-1:0] regs [REG_COUNT];
  logic [AW-1:0]  wa;
  logic           in_range;
  logic           wr_hit;

  logic [CW-1:0] cnt;
  logic          tick;

  logic [7:0] sec_n, min_n, hour_n;
  logic       sec_c, min_c, hour_c;
  logic       sec_go, min_go;

  // synchronize strobes, pipeline bus data to match, keep edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      ad_sy <= 2'b00;
      cs_sy <= 2'b11;
      wr_sy <= 2'b11;
      rd_sy <= 2'b11;
      wr_q  <= 1'b1;
      rd_q  <= 1'b1;
      d1    <= '0;
      d2    <= '0;
    end else begin
      ad_sy <= {ad_sy[0], AD};
      cs_sy <= {cs_sy[0], CS};
      wr_sy <= {wr_sy[0], WR};
      rd_sy <= {rd_sy[0], RD};
      wr_q  <= wr_sy[1];
      rd_q  <= rd_sy[1];
      d1    <= AD0_AD7;
      d2    <= d1;
    end
  end

  assign ad_s = ad_sy[1];
  assign cs_s = cs_sy[1];
  assign wr_s = wr_sy[1];
  assign rd_s = rd_sy[1];

  assign wr_fall = wr_q & ~wr_s;
  assign wr_rise = ~wr_q & wr_s;
  assign rd_fall = rd_q & ~rd_s;
  assign rd_rise = ~rd_q & rd_s;
  assign err     = ~wr_s & ~rd_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // FSM next state; deselect or both strobes low force IDLE
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (!cs_s && wr_fall) begin
          nstate = ad_s ? DATA_WR : ADDR_PH;
        end else if (!cs_s && rd_fall && ad_s) begin
          nstate = DATA_RD;
        end
      end
      ADDR_PH,
      DATA_WR: begin
        if (wr_rise) nstate = IDLE;
      end
      DATA_RD: begin
        if (rd_rise) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    if (cs_s || err) nstate = IDLE;
  end

  // FSM outputs: closing WR edge commits, DATA_RD drives
  always_comb begin
    latch_addr = (state == ADDR_PH) && wr_rise && !cs_s;
    commit     = (state == DATA_WR) && wr_rise && !cs_s;
    rd_active  = (state == DATA_RD);
  end

  assign wa       = addr_latched[AW-1:0];
  assign in_range = {1'b0, addr_latched} < REG_LIM;
  assign wr_hit   = commit && in_range;

  // address latch, write pulse and read-back register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_latched <= '0;
      wr_pulse     <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (latch_addr) addr_latched <= d2;
      wr_pulse <= commit;
      rd_data  <= in_range ? regs[wa] : '0;
    end
  end

  assign AD0_AD7 = rd_active ? rd_data : {LAR{1'bz}};

  // free-running one-second divider
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX) &&
                !regs[A_CTRL][HOLD_BIT];

  rtc_bus_responder_bcd_inc u_sec (
    .val   (regs[A_SEC]),
    .limit (SEC_LIM),
    .nxt   (sec_n),
    .carry (sec_c)
  );

  rtc_bus_responder_bcd_inc u_min (
    .val   (regs[A_MIN]),
    .limit (MIN_LIM),
    .nxt   (min_n),
    .carry (min_c)
  );

  rtc_bus_responder_bcd_inc u_hour (
    .val   (regs[A_HOUR]),
    .limit (HOUR_LIM),
    .nxt   (hour_n),
    .carry (hour_c)
  );

  // a register being written this cycle does not pass a carry on
  assign sec_go = sec_c && !(wr_hit && wa == A_SEC);
  assign min_go = sec_go && min_c &&
                  !(wr_hit && wa == A_MIN);

  // register file: clock update first, bus write overrides
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (tick) begin
        regs[A_SEC] <= sec_n;
        if (sec_go) regs[A_MIN]  <= min_n;
        if (min_go) regs[A_HOUR] <= hour_n;
      end
      if (wr_hit) regs[wa] <= d2;
    end
  end

  logic unused_hour_c;
  assign unused_hour_c = hour_c;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder.
// Cycle model from bus timing rules plus literal read-backs.
module tb_rtc_bus_responder;

  localparam int T   = 16;
  localparam int BIG = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ad  = 1'b0;
  logic       cs  = 1'b1;
  logic       wr  = 1'b1;
  logic       rd  = 1'b1;
  logic [7:0] tb_data  = 8'h00;
  logic       tb_drive = 1'b0;

  wire  [7:0] bus;
  logic [7:0] addr_latched;
  logic       wr_pulse;
  logic       rd_active;

  assign bus = tb_drive ? tb_data : 8'hzz;

  rtc_bus_responder #(
    .LAR       (8),
    .REG_COUNT (64),
    .TICK_DIV  (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .AD0_AD7      (bus),
    .AD           (ad),
    .CS           (cs),
    .WR           (wr),
    .RD           (rd),
    .addr_latched (addr_latched),
    .wr_pulse     (wr_pulse),
    .rd_active    (rd_active)
  );

  always #5 clk = ~clk;

  logic [7:0] m [64];
  logic [7:0] maddr;
  int         k;
  int         rd_on  = BIG;
  int         rd_off = BIG;
  int         wc_k   = -1;
  logic       wc_data = 1'b0;
  logic [7:0] wc_d    = 8'h00;
  logic       exp_rd, exp_wp;
  logic [7:0] exp_bus;
  logic       live = 1'b0;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, req, $time);
    end
  endtask

  // decimal view of a BCD byte; returns {carry, next}
  function automatic logic [8:0] bcd_next(
    input logic [7:0] v, input int lim);
    int dec;
    if (v[7:4] > 9 || v[3:0] > 9) return {1'b1, 8'h00};
    dec = v[7:4] * 10 + v[3:0];
    if (dec >= lim) return {1'b1, 8'h00};
    dec++;
    return {1'b0, 4'(dec / 10), 4'(dec % 10)};
  endfunction

  // reference: k counts clocks since reset, ticks every T-th,
  // bus actions take effect three clocks after the raw edge
  always @(posedge clk) begin
    logic [8:0] r;
    logic       c;
    logic       wnow;
    logic [7:0] wa;
    live = 1'b1;
    if (rst) begin
      foreach (m[i]) m[i] = 8'h00;
      maddr   = 8'h00;
      k       = 0;
      rd_on   = BIG;
      rd_off  = BIG;
      wc_k    = -1;
      exp_rd  = 1'b0;
      exp_wp  = 1'b0;
      exp_bus = 8'h00;
    end else begin
      k++;
      exp_bus = (maddr < 64) ? m[maddr[5:0]] : 8'h00;
      wnow = (k == wc_k) && wc_data;
      wa   = wnow ? maddr : 8'hff;
      if ((k % T) == 0 && !m[0][0]) begin
        r = bcd_next(m[33], 59);
        m[33] = r[7:0];
        c = r[8] && (wa != 8'h21);
        if (c) begin
          r = bcd_next(m[34], 59);
          m[34] = r[7:0];
          c = r[8] && (wa != 8'h22);
          if (c) begin
            r = bcd_next(m[35], 23);
            m[35] = r[7:0];
          end
        end
      end
      exp_wp = wnow;
      if (k == wc_k) begin
        if (!wc_data) maddr = wc_d;
        else if (maddr < 64) m[maddr[5:0]] = wc_d;
      end
      exp_rd = (k >= rd_on) && (k < rd_off);
    end
  end

  // every-cycle comparison against the reference
  always @(negedge clk) begin
    if (live) begin
      chk("rd_active", {7'd0, rd_active}, {7'd0, exp_rd});
      chk("wr_pulse", {7'd0, wr_pulse}, {7'd0, exp_wp});
      chk("addr_latched", addr_latched, maddr);
      if (exp_rd) chk("bus", bus, exp_bus);
    end
  end

  task automatic phase_wr(input logic adv,
                          input logic [7:0] d,
                          input int align);
    @(negedge clk);
    ad = adv; cs = 1'b0;
    tb_data = d; tb_drive = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < T && align >= 0
         && ((k + 3) % T) != align; i++)
      @(negedge clk);
    wr = 1'b1;
    wc_k = k + 3; wc_data = adv; wc_d = d;
    repeat (4) @(negedge clk);
    cs = 1'b1; tb_drive = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a,
                        input logic [7:0] d);
    phase_wr(1'b0, a, -1);
    phase_wr(1'b1, d, -1);
  endtask

  task automatic rd_reg(input logic [7:0] a,
                        output logic [7:0] v);
    phase_wr(1'b0, a, -1);
    @(negedge clk);
    ad = 1'b1; cs = 1'b0;
    @(negedge clk);
    rd = 1'b0;
    rd_on = k + 3; rd_off = BIG;
    repeat (4) @(negedge clk);
    v = bus;
    rd = 1'b1;
    rd_off = k + 3;
    repeat (4) @(negedge clk);
    cs = 1'b1;
  endtask

  // one tick passes between clearing and re-setting HOLD
  task automatic hold_gap();
    phase_wr(1'b0, 8'h00, -1);
    phase_wr(1'b1, 8'h00, T - 6);
    phase_wr(1'b1, 8'h01, -1);
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h21;
      2: return 8'h22;
      3: return 8'h23;
      default: return 8'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    logic [7:0] v;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    wr_reg(8'h10, 8'ha5);
    rd_reg(8'h10, v);
    chk("rd_0x10", v, 8'ha5);

    wr_reg(8'h7f, 8'h33);
    rd_reg(8'h7f, v);
    chk("rd_0x7f", v, 8'h00);
    rd_reg(8'h3f, v);
    chk("rd_0x3f_alias", v, 8'h00);

    wr_reg(8'h00, 8'h01);
    wr_reg(8'h21, 8'h12);
    repeat (10 * T) @(negedge clk);
    rd_reg(8'h21, v);
    chk("hold_sec", v, 8'h12);
    hold_gap();
    rd_reg(8'h21, v);
    chk("unhold_sec", v, 8'h13);

    wr_reg(8'h23, 8'h23);
    wr_reg(8'h22, 8'h59);
    wr_reg(8'h21, 8'h59);
    hold_gap();
    rd_reg(8'h21, v);
    chk("roll_sec", v, 8'h00);
    rd_reg(8'h22, v);
    chk("roll_min", v, 8'h00);
    rd_reg(8'h23, v);
    chk("roll_hour", v, 8'h00);

    wr_reg(8'h00, 8'h00);
    wr_reg(8'h22, 8'h07);
    phase_wr(1'b0, 8'h21, -1);
    phase_wr(1'b1, 8'h59, 1);
    phase_wr(1'b1, 8'h40, 0);
    wr_reg(8'h00, 8'h01);
    rd_reg(8'h22, v);
    chk("collide_min", v, 8'h07);
    // the tick after the collision lands before HOLD returns
    rd_reg(8'h21, v);
    chk("collide_sec", v, 8'h41);

    @(negedge clk);
    ad = 1'b1; cs = 1'b0;
    tb_data = 8'hff; tb_drive = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    wr = 1'b1;
    repeat (4) @(negedge clk);
    tb_drive = 1'b0;
    rd_reg(8'h21, v);
    chk("abort_sec", v, 8'h41);

    @(negedge clk);
    ad = 1'b1; cs = 1'b0;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (6) @(negedge clk);
    rd = 1'b1; wr = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    rd = 1'b0;
    rd_on = k + 3; rd_off = BIG;
    repeat (5) @(negedge clk);
    wr = 1'b0;
    rd_off = k + 3;
    repeat (5) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
    rd = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    rd_reg(8'h21, v);
    chk("err_sec", v, 8'h41);

    phase_wr(1'b0, 8'h21, -1);
    @(negedge clk);
    ad = 1'b1; cs = 1'b0;
    @(negedge clk);
    rd = 1'b0;
    rd_on = k + 3; rd_off = BIG;
    repeat (4) @(negedge clk);
    rst = 1'b1; rd = 1'b1; cs = 1'b1;
    @(negedge clk);
    chk("rst_release", {7'd0, rd_active}, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_reg(8'h21, v);
    chk("rst_sec", v, 8'h00);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: phase_wr(1'b0, pick_addr(), -1);
        1, 2: phase_wr(1'b1, 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0) ?
                       $urandom_range(0, T - 1) : -1);
        3, 4: rd_reg(pick_addr(), v);
        default: repeat ($urandom_range(1, 20))
                   @(negedge clk);
      endcase
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout want finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
